// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Sizes follow the load/store unit encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp,
        StErr
    } state_e;

    typedef enum logic {
        OwnFetch,
        OwnData
    } owner_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_lane.sv
// Byte-lane steering for one request: byte enables, replicated store data
// and the alignment check for the access size.
module mem_arb_lane
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = off_i[0];
            end
            SZ_W: begin
                be_o       = BE_WORD;
                misalign_o = |off_i;
            end
            default: be_o = 4'b0000;
        endcase
        // Loads always read the whole word; the load unit extracts lanes.
        if (!we_i) begin
            be_o = BE_WORD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported word memory between instruction fetch and load/store.
// Data has priority, but a fetch waiting at a data completion is served next.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_AW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_ack_o,
    output logic [31:0]       if_rdata_o,
    output logic              if_err_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_ack_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    state_e            state_q;
    owner_e            owner_q;
    logic              fair_q;
    logic              we_q;
    logic              if_ack_q, d_ack_q, if_err_q, d_err_q;
    logic              rd_if_q, rd_d_q;
    logic              mem_en_q, mem_we_q;
    logic [3:0]        mem_be_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic        can_grant, cand_if, cand_d, fetch_first, grant_if, grant_d;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_we, sel_err;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misalign;

    // An ack register is high exactly while its requester sits in RESP/ERR,
    // so it doubles as the "being acked" exclusion for that requester.
    assign can_grant   = (state_q != StIssue);
    assign cand_if     = can_grant & if_req_i & ~if_ack_q;
    assign cand_d      = can_grant & d_req_i & ~d_ack_q;
    assign fetch_first = fair_q | (d_ack_q & if_req_i);
    assign grant_if    = cand_if & (~cand_d | fetch_first);
    assign grant_d     = cand_d & ~grant_if;

    assign sel_addr = grant_d ? d_addr_i : if_addr_i;
    assign sel_size = grant_d ? d_size_i : SZ_W;
    assign sel_we   = grant_d & d_we_i;

    mem_arb_lane u_lane (
        .size_i     (sel_size),
        .off_i      (sel_addr[1:0]),
        .wdata_i    (d_wdata_i),
        .we_i       (sel_we),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .misalign_o (lane_misalign)
    );

    assign sel_err = lane_misalign | (|sel_addr[31:MEM_AW+2]) | (grant_d & (d_size_i == SZ_ILL));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            owner_q     <= OwnFetch;
            fair_q      <= 1'b0;
            we_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            rd_if_q     <= 1'b0;
            rd_d_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if_err_q <= 1'b0;
            d_err_q  <= 1'b0;
            rd_if_q  <= 1'b0;
            rd_d_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;

            if (grant_if) begin
                fair_q <= 1'b0;
            end else if (d_ack_q && if_req_i) begin
                fair_q <= 1'b1;
            end

            if (state_q == StIssue) begin
                state_q <= StResp;
                if (owner_q == OwnData) begin
                    d_ack_q <= 1'b1;
                    rd_d_q  <= ~we_q;
                end else begin
                    if_ack_q <= 1'b1;
                    rd_if_q  <= 1'b1;
                end
            end else if (grant_if || grant_d) begin
                owner_q <= grant_d ? OwnData : OwnFetch;
                we_q    <= sel_we;
                if (sel_err) begin
                    state_q  <= StErr;
                    if_ack_q <= grant_if;
                    if_err_q <= grant_if;
                    d_ack_q  <= grant_d;
                    d_err_q  <= grant_d;
                end else begin
                    state_q     <= StIssue;
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= sel_we;
                    mem_be_q    <= lane_be;
                    mem_addr_q  <= sel_addr[MEM_AW+1:2];
                    mem_wdata_q <= lane_wdata;
                end
            end else begin
                state_q <= StIdle;
            end
        end
    end

    // Read data arrives from the array during RESP; only the lane select is registered.
    assign if_rdata_o  = rd_if_q ? mem_rdata_i : '0;
    assign d_rdata_o   = rd_d_q ? mem_rdata_i : '0;
    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign if_err_o    = if_err_q;
    assign d_err_o     = d_err_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
